// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pulls one word at a time from an upstream FIFO and transmits it as an
// 8N1-style serial frame: one start bit (0), DATA_WIDTH data bits LSB first,
// one stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
// Frames run back-to-back while enable is high and the FIFO is non-empty.
//
// Ports:
//   clock        - single clock, all state updates on the rising edge
//   reset_n      - asynchronous active-low reset
//   enable       - allows a new frame to start; a frame in progress always completes
//   buffer_out   - FIFO read data, valid the cycle after a granted read
//   buffer_empty - FIFO empty flag
//   read_enable  - one-cycle FIFO read request (high only in READ)
//   tx           - serial output, idle high
//   busy         - high whenever the FSM is not in IDLE
//   byte_done    - one-cycle pulse in the cycle after the final stop-bit cycle
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] buffer_out,
    input  logic                  buffer_empty,
    output logic                  read_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         baud_cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  bit_end;
    logic                  can_start;

    assign bit_end   = (baud_cnt == CNT_MAX);
    assign can_start = enable && !buffer_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            byte_done <= 1'b0;
        end else begin
            state     <= state_next;
            byte_done <= (state == STOP) && bit_end;

            // Baud counter only runs while a bit is on the line; it is parked
            // at zero otherwise so every START begins a full bit period.
            if (state == START || state == DATA || state == STOP) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
            end else begin
                baud_cnt <= '0;
            end

            if (state == LOAD) begin
                shift_reg <= buffer_out;
                bit_idx   <= '0;
            end else if (state == DATA && bit_end) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= (bit_idx == BIT_MAX) ? '0 : bit_idx + BW'(1);
            end
        end
    end

    always_comb begin
        state_next  = state;
        read_enable = 1'b0;
        busy        = 1'b1;
        tx          = 1'b1;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (can_start) state_next = READ;
            end
            READ: begin
                read_enable = 1'b1;
                state_next  = LOAD;
            end
            LOAD: begin
                state_next = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                tx = shift_reg[0];
                if (bit_end && bit_idx == BIT_MAX) state_next = STOP;
            end
            STOP: begin
                // Chain straight into the next fetch so back-to-back frames
                // carry only the two-cycle READ/LOAD gap.
                if (bit_end) state_next = can_start ? READ : IDLE;
            end
            default: begin
                state_next = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] buffer_out = 8'h00;
    logic       buffer_empty = 1'b1;
    logic       read_enable;
    logic       tx;
    logic       busy;
    logic       byte_done;

    logic       enable2;
    logic [7:0] buffer_out2;
    logic       buffer_empty2;
    logic       read_enable2;
    logic       tx2;
    logic       busy2;
    logic       byte_done2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fifo_q[$];
    logic       rd_pending;
    logic [3:0] exp_q[$];

    always #5 clock = ~clock;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .buffer_out(buffer_out), .buffer_empty(buffer_empty),
        .read_enable(read_enable), .tx(tx), .busy(busy), .byte_done(byte_done)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .enable(enable2),
        .buffer_out(buffer_out2), .buffer_empty(buffer_empty2),
        .read_enable(read_enable2), .tx(tx2), .busy(busy2), .byte_done(byte_done2)
    );

    // Upstream FIFO model: a read granted at one rising edge presents data
    // during the following cycle.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_pending <= 1'b0;
        else          rd_pending <= read_enable;
    end

    always @(negedge clock) begin
        if (rd_pending && fifo_q.size() > 0) buffer_out = fifo_q.pop_front();
        buffer_empty = (fifo_q.size() == 0);
    end

    // Expected per-cycle {tx, busy, read_enable, byte_done}, starting at the
    // READ cycle of the first frame, for frames fetched back-to-back.
    function automatic void build_model(input logic [7:0] bytes[$], input int c);
        int         period;
        int         frame;
        int         off;
        int         b;
        logic [7:0] d;
        logic       txv;
        period = 10 * c + 2;
        exp_q.delete();
        for (int t = 0; t <= bytes.size() * period; t++) begin
            frame = t / period;
            off   = t % period;
            if (frame == bytes.size()) begin
                exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1});
            end else begin
                txv = 1'b1;
                if (off >= 2) begin
                    b = (off - 2) / c;
                    d = bytes[frame];
                    if (b == 0)      txv = 1'b0;
                    else if (b <= 8) txv = d[b-1];
                end
                exp_q.push_back({txv, 1'b1, (off == 0), (off == 0 && frame > 0)});
            end
        end
    endfunction

    task automatic wait_read(input logic which, input int limit, output logic found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((which ? read_enable2 : read_enable) === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; enable2 = 1'b0;
        buffer_out2 = 8'h00; buffer_empty2 = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({tx, busy, read_enable, byte_done} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_state: {tx,busy,re,done}=%b required 1000", {tx, busy, read_enable, byte_done});
        end
        n_cmp++;
        if ({tx2, busy2, read_enable2, byte_done2} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_state2: {tx,busy,re,done}=%b required 1000", {tx2, busy2, read_enable2, byte_done2});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_byte();
        logic [7:0] b[$];
        logic       found;
        b = '{8'hA5};
        fifo_q.push_back(8'hA5);
        enable = 1'b1;
        wait_read(1'b0, 10, found);
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++;
            $display("FAIL single_start: read_enable seen=%b required 1", found);
        end else begin
            build_model(b, 4);
            foreach (exp_q[t]) begin
                n_cmp++;
                if ({tx, busy, read_enable, byte_done} !== exp_q[t]) begin
                    n_err++;
                    $display("FAIL single_trace t=%0d: {tx,busy,re,done}=%b required %b", t, {tx, busy, read_enable, byte_done}, exp_q[t]);
                end
                @(negedge clock);
            end
        end
        enable = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_back_to_back(input logic [7:0] bytes[$], input string name);
        logic found;
        foreach (bytes[i]) fifo_q.push_back(bytes[i]);
        enable = 1'b1;
        wait_read(1'b0, 10, found);
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++;
            $display("FAIL %s_start: read_enable seen=%b required 1", name, found);
        end else begin
            build_model(bytes, 4);
            foreach (exp_q[t]) begin
                n_cmp++;
                if ({tx, busy, read_enable, byte_done} !== exp_q[t]) begin
                    n_err++;
                    $display("FAIL %s_trace t=%0d: {tx,busy,re,done}=%b required %b", name, t, {tx, busy, read_enable, byte_done}, exp_q[t]);
                end
                @(negedge clock);
            end
        end
        enable = 1'b0;
        fifo_q.delete();
        repeat (2) @(negedge clock);
    endtask

    task automatic test_random();
        logic [7:0] bytes[$];
        int         n;
        for (int it = 0; it < 3; it++) begin
            bytes.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
            test_back_to_back(bytes, "random");
        end
    endtask

    task automatic test_empty_fifo();
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({tx, busy, read_enable} !== 3'b100) begin
                n_err++;
                $display("FAIL empty_idle cyc=%0d: {tx,busy,re}=%b required 100", i, {tx, busy, read_enable});
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [7:0] b[$];
        logic       found;
        b = '{8'h3C};
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h99);
        enable = 1'b1;
        wait_read(1'b0, 10, found);
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++;
            $display("FAIL drop_start: read_enable seen=%b required 1", found);
        end else begin
            build_model(b, 4);
            foreach (exp_q[t]) begin
                n_cmp++;
                if ({tx, busy, read_enable, byte_done} !== exp_q[t]) begin
                    n_err++;
                    $display("FAIL drop_trace t=%0d: {tx,busy,re,done}=%b required %b", t, {tx, busy, read_enable, byte_done}, exp_q[t]);
                end
                if (t == 10) enable = 1'b0;
                @(negedge clock);
            end
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({busy, read_enable, buffer_empty} !== 3'b000) begin
                n_err++;
                $display("FAIL drop_hold cyc=%0d: {busy,re,empty}=%b required 000", i, {busy, read_enable, buffer_empty});
            end
            @(negedge clock);
        end
        enable = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (read_enable !== 1'b1) begin
            n_err++;
            $display("FAIL drop_resume: read_enable=%b required 1", read_enable);
        end
        enable = 1'b0;
        for (int i = 0; i < 60 && busy === 1'b1; i++) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_finish: busy=%b required 0", busy);
        end
        fifo_q.delete();
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b[$];
        logic       found;
        b = '{8'h55};
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h12);
        enable = 1'b1;
        wait_read(1'b0, 10, found);
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_start: read_enable seen=%b required 1", found);
        end else begin
            build_model(b, 4);
            for (int t = 0; t < 19; t++) begin
                n_cmp++;
                if ({tx, busy, read_enable, byte_done} !== exp_q[t]) begin
                    n_err++;
                    $display("FAIL rstmid_trace t=%0d: {tx,busy,re,done}=%b required %b", t, {tx, busy, read_enable, byte_done}, exp_q[t]);
                end
                @(negedge clock);
            end
        end
        // Now in data bit 3; assert reset between edges.
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx, busy, read_enable, byte_done} !== 4'b1000) begin
            n_err++;
            $display("FAIL rstmid_async: {tx,busy,re,done}=%b required 1000", {tx, busy, read_enable, byte_done});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({read_enable, byte_done} !== 2'b00) begin
                n_err++;
                $display("FAIL rstmid_hold cyc=%0d: {re,done}=%b required 00", i, {read_enable, byte_done});
            end
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (read_enable !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_restart: read_enable=%b required 1", read_enable);
        end else begin
            b = '{8'h12};
            build_model(b, 4);
            foreach (exp_q[t]) begin
                n_cmp++;
                if ({tx, busy, read_enable, byte_done} !== exp_q[t]) begin
                    n_err++;
                    $display("FAIL rstmid_frame t=%0d: {tx,busy,re,done}=%b required %b", t, {tx, busy, read_enable, byte_done}, exp_q[t]);
                end
                @(negedge clock);
            end
        end
        enable = 1'b0;
        fifo_q.delete();
        repeat (2) @(negedge clock);
    endtask

    task automatic test_min_baud();
        logic [7:0] b[$];
        logic       found;
        b = '{8'h80};
        buffer_out2   = 8'h80;
        buffer_empty2 = 1'b0;
        enable2       = 1'b1;
        wait_read(1'b1, 10, found);
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++;
            $display("FAIL minbaud_start: read_enable seen=%b required 1", found);
        end else begin
            buffer_empty2 = 1'b1;
            build_model(b, 2);
            foreach (exp_q[t]) begin
                n_cmp++;
                if ({tx2, busy2, read_enable2, byte_done2} !== exp_q[t]) begin
                    n_err++;
                    $display("FAIL minbaud_trace t=%0d: {tx,busy,re,done}=%b required %b", t, {tx2, busy2, read_enable2, byte_done2}, exp_q[t]);
                end
                @(negedge clock);
            end
        end
        enable2       = 1'b0;
        buffer_empty2 = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back('{8'h01, 8'hFF, 8'h00}, "b2b");
        test_random();
        test_empty_fifo();
        test_enable_drop();
        test_reset_mid_frame();
        test_min_baud();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of each FIFO word and of the serial data field.
REQ-002 Parameter: CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is 2 or more.
REQ-003 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: enable  input  1  permits a new frame to start; has no effect on a frame in progress.
REQ-006 Port: buffer_out  input  DATA_WIDTH  data word from the upstream FIFO, valid the cycle after a granted read.
REQ-007 Port: buffer_empty  input  1  upstream FIFO empty flag.
REQ-008 Port: read_enable  output  1  single-cycle read request to the upstream FIFO.
REQ-009 Port: tx  output  1  serial line; idle high.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: byte_done  output  1  one-cycle pulse marking a completed frame.

Function
REQ-012 The FSM SHALL have states IDLE, READ, LOAD, START, DATA and STOP; all outputs are registered or decoded from state only.
REQ-013 In IDLE, with enable=1 and buffer_empty=0 sampled at the edge, the next state SHALL be READ; otherwise the FSM SHALL remain in IDLE.
REQ-014 read_enable SHALL be 1 only during READ, which SHALL last exactly one cycle; the next state is LOAD.
REQ-015 LOAD SHALL last one cycle; at its closing edge buffer_out SHALL be captured into a DATA_WIDTH shift register; the next state is START.
REQ-016 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles.
REQ-017 DATA SHALL drive DATA_WIDTH bits, LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-018 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles; in IDLE, READ and LOAD, tx SHALL also be 1.
REQ-019 Baud counter width SHALL be $clog2(CLKS_PER_BIT) bits; bit index width SHALL be $clog2(DATA_WIDTH) bits, minimum 1.
REQ-020 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary, with no off-by-one.
REQ-021 At the final STOP cycle the next state SHALL be READ if enable=1 and buffer_empty=0; otherwise it SHALL be IDLE.
REQ-022 byte_done SHALL be 1 for exactly the one cycle following the final STOP cycle.
REQ-023 Frame start to next frame start, back-to-back, SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT+2 cycles.
REQ-024 Deasserting enable mid-frame SHALL NOT truncate the frame; it only blocks the next frame.
REQ-025 A change on buffer_empty outside IDLE, or outside the final STOP cycle, SHALL be ignored.
REQ-026 read_enable SHALL NEVER be asserted while buffer_empty=1 was sampled at the deciding edge.

Reset
REQ-027 When reset_n=0, the block SHALL immediately (asynchronously) reach: state=IDLE, tx=1, read_enable=0, busy=0, byte_done=0, counters=0, shift register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further read_enable and no byte_done.
REQ-029 After reset_n rises, the first frame SHALL start only through IDLE->READ per REQ-013.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-030 Single byte: FIFO holds 0xA5, enable=1 -> one read_enable pulse; tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1; byte_done pulses 1 cycle after stop; busy high for 42 cycles.
REQ-031 Back-to-back: FIFO holds 0x01,0xFF,0x00 -> three frames with start edges 42 cycles apart; data bits match LSB-first; exactly three read_enable pulses.
REQ-032 Empty FIFO: buffer_empty=1, enable=1 for 100 cycles -> read_enable=0, tx=1, busy=0 throughout.
REQ-033 Enable drop: enable->0 during DATA of 0x3C -> frame completes intact; no further read_enable while enable=0 although FIFO is non-empty.
REQ-034 Reset mid-frame: reset_n=0 in bit 3 of 0x55 -> tx=1 and busy=0 within the same cycle; no byte_done; after release with FIFO non-empty, a new frame begins via READ.
REQ-035 Minimum baud: CLKS_PER_BIT=2, byte 0x80 -> every bit lasts 2 cycles; frame is 20 cycles plus 2 fetch cycles.
